// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding, parity modes and frame sizing.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_tx_state_t;

  localparam int unsigned PAR_NONE = 0;
  localparam int unsigned PAR_EVEN = 1;
  localparam int unsigned PAR_ODD  = 2;

  // Serial bits in one frame: start + data + optional parity + stop bits.
  function automatic int unsigned frame_bits(input int unsigned data_bits,
                                             input int unsigned parity,
                                             input int unsigned stop_bits);
    return 1 + data_bits + ((parity != PAR_NONE) ? 1 : 0) + stop_bits;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Baud divider: marks the last clk cycle of every serial bit period; restart realigns to a new bit.
module uart_baud_tick #(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic clk,
  input  logic reset_n,
  input  logic restart,
  output logic bit_end,
  output logic bit_end_next_c
);

  localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;

  // bit_end_next_c lets the parent register signals that must coincide with bit_end.
  always_comb begin
    cnt_next = cnt + CW'(1);
    if (restart || (cnt == LAST)) begin
      cnt_next = '0;
    end
    bit_end_next_c = (cnt_next == LAST);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt     <= '0;
      bit_end <= (LAST == '0);
    end else begin
      cnt     <= cnt_next;
      bit_end <= bit_end_next_c;
    end
  end

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmitter: one word per valid/ready handshake, configurable data/parity/stop framing,
// back-to-back frames when a new word arrives in the final stop cycle.
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned PARITY       = 0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 txd,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam int unsigned BW = $clog2(DATA_BITS + 1);

  if ((DATA_BITS < 5) || (DATA_BITS > 9)) begin : g_bad_data_bits
    $error("uart_tx_frame: DATA_BITS must be 5..9");
  end
  if (CLKS_PER_BIT < 1) begin : g_bad_clks_per_bit
    $error("uart_tx_frame: CLKS_PER_BIT must be at least 1");
  end
  if ((PARITY != PAR_NONE) && (PARITY != PAR_EVEN) && (PARITY != PAR_ODD)) begin : g_bad_parity
    $error("uart_tx_frame: PARITY must be 0, 1 or 2");
  end
  if ((STOP_BITS < 1) || (STOP_BITS > 2)) begin : g_bad_stop_bits
    $error("uart_tx_frame: STOP_BITS must be 1 or 2");
  end

  uart_tx_state_t       state, state_next;
  logic [DATA_BITS-1:0] shift, shift_next;
  logic [BW-1:0]        bit_cnt, bit_cnt_next;
  logic                 par, par_next;
  logic                 txd_next, busy_next, ready_next, done_next;
  logic                 handshake, restart, last_c;
  logic                 bit_end, bit_end_next_c;

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk           (clk),
    .reset_n       (reset_n),
    .restart       (restart),
    .bit_end       (bit_end),
    .bit_end_next_c(bit_end_next_c)
  );

  // bit_cnt counts remaining data bits, then is reused for remaining stop bits.
  always_comb begin
    state_next   = state;
    shift_next   = shift;
    bit_cnt_next = bit_cnt;
    par_next     = par;
    restart      = 1'b0;
    handshake    = tx_valid && tx_ready;
    last_c       = (state == ST_STOP) && bit_end && (bit_cnt == BW'(1));

    case (state)
      ST_IDLE:  state_next = ST_IDLE;
      ST_START: if (bit_end) state_next = ST_DATA;
      ST_DATA: begin
        if (bit_end) begin
          shift_next   = shift >> 1;
          bit_cnt_next = bit_cnt - BW'(1);
          if (bit_cnt == BW'(1)) begin
            state_next   = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
            bit_cnt_next = BW'(STOP_BITS);
          end
        end
      end
      ST_PARITY: begin
        if (bit_end) begin
          state_next   = ST_STOP;
          bit_cnt_next = BW'(STOP_BITS);
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          bit_cnt_next = bit_cnt - BW'(1);
          if (bit_cnt == BW'(1)) state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase

    if (handshake) begin
      state_next   = ST_START;
      shift_next   = tx_data;
      bit_cnt_next = BW'(DATA_BITS);
      par_next     = (^tx_data) ^ (PARITY == PAR_ODD);
      restart      = 1'b1;
    end

    case (state_next)
      ST_START:  txd_next = 1'b0;
      ST_DATA:   txd_next = shift_next[0];
      ST_PARITY: txd_next = par_next;
      default:   txd_next = 1'b1;
    endcase

    busy_next  = (state_next != ST_IDLE);
    // Ready is registered, so look one cycle ahead for the final stop cycle.
    ready_next = (state_next == ST_IDLE) ||
                 ((state_next == ST_STOP) && (bit_cnt_next == BW'(1)) && bit_end_next_c);
    done_next  = last_c;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      shift    <= '0;
      bit_cnt  <= '0;
      par      <= 1'b0;
      txd      <= 1'b1;
      tx_busy  <= 1'b0;
      tx_ready <= 1'b1;
      tx_done  <= 1'b0;
    end else begin
      state    <= state_next;
      shift    <= shift_next;
      bit_cnt  <= bit_cnt_next;
      par      <= par_next;
      txd      <= txd_next;
      tx_busy  <= busy_next;
      tx_ready <= ready_next;
      tx_done  <= done_next;
    end
  end

endmodule

// File: doc/uart_tx_frame.md
# uart_tx_frame

Parametrised UART transmitter that serialises one word per valid/ready handshake into a configurable asynchronous frame: start bit, DATA_BITS data bits LSB first, optional parity, and 1 or 2 stop bits, each held for CLKS_PER_BIT clocks. It is the next-generation replacement for the fixed 8N1, one-bit-per-clock, button-triggered transmitter. It sits between a byte source (FIFO or command logic) and the board TXD pin. A one-cycle completion pulse replaces the old sticky-flag/delete handshake.

## Interface

Parameters:
- DATA_BITS, 8: data bits per frame, legal 5..9.
- CLKS_PER_BIT, 434: clk cycles per serial bit (baud divider), legal ≥1.
- PARITY, 0: 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1: number of stop bits, legal 1 or 2.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  reset, asynchronous, active-low.
- tx_data  in  DATA_BITS  word to send; sampled only on the handshake cycle.
- tx_valid  in  1  source has a word.
- tx_ready  out  1  block can accept a word this cycle.
- txd  out  1  serial line; idle high.
- tx_busy  out  1  a frame is on the line (start bit through final stop bit).
- tx_done  out  1  one-cycle pulse, frame finished.

## Operation

- States: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - txd=1, tx_busy=0, tx_ready=1.
  - On tx_valid&&tx_ready: capture tx_data into the shift register, load the bit counter, and enter START.
- START: txd=0 for CLKS_PER_BIT cycles.
- DATA:
  - txd = shift[0] for each bit period.
  - Shift right at each bit boundary.
  - After DATA_BITS bits, go to PARITY if PARITY≠0, otherwise to STOP.
- PARITY:
  - Parity bit is computed at capture: XOR of the captured word for even, inverted XOR for odd.
  - Held for one bit period.
- STOP: txd=1 for STOP_BITS×CLKS_PER_BIT cycles.
- Handshake:
  - tx_ready=1 in IDLE and in the final clk cycle of the last stop bit; 0 elsewhere.
  - Handshake in that final stop cycle: go straight to START next cycle (back-to-back, no idle gap).
  - Otherwise return to IDLE.
- tx_valid while tx_ready=0 is ignored. The source holds it; no data loss, no queueing.
- tx_data changes after capture do not affect the frame in flight.
- tx_done is asserted for exactly one cycle: the cycle after the last stop-bit cycle, for every completed frame including back-to-back ones.
- Baud counter:
  - Width $clog2(CLKS_PER_BIT) (minimum 1). Counts 0..CLKS_PER_BIT-1, wraps to 0 at each bit boundary.
  - Reloaded to 0 on each handshake.
  - CLKS_PER_BIT=1 gives one bit per clock.
- Bit counter width: $clog2(DATA_BITS+1).

## Timing

- Reset values:
  - txd=1, tx_ready=1 (IDLE), tx_busy=0, tx_done=0.
  - Shift register and counters are 0.
- Reset mid-frame aborts immediately (asynchronous). txd goes high at once; no tx_done is produced.
- Latency: handshake on cycle N, txd=0 and tx_busy=1 from cycle N+1.
- Frame length F = (1 + DATA_BITS + (PARITY≠0) + STOP_BITS) × CLKS_PER_BIT cycles. txd is valid from N+1 through N+F.
- tx_done is high on cycle N+F+1.
- tx_busy is high on cycles N+1..N+F. It stays continuously high across back-to-back frames.
- All outputs are registered; txd is glitch-free.

## Structure

- Package uart_pkg holds:
  - state enum uart_tx_state_t;
  - parity constants PAR_NONE/PAR_EVEN/PAR_ODD;
  - a function computing frame length in bits, shared with the future uart_rx_frame.
- Sub-module uart_baud_tick:
  - Parametrised by CLKS_PER_BIT; inputs clk, reset_n, restart.
  - Output bit_end is high on the final cycle of each bit period.
  - To be reused by the receiver.
- Parameter legality is checked by elaboration-time assertions.

## Test plan

- 8E1, CLKS_PER_BIT=4, send 0xA5 -> txd per 4-cycle bit: 0, 1,0,1,0,0,1,0,1, parity 0, stop 1; tx_done pulses on cycle N+45; tx_busy high 44 cycles.
- 8O2, CLKS_PER_BIT=4, send 0xA5 -> parity bit 1, stop high 8 cycles, F=48, tx_done at N+49.
- 8N1, CLKS_PER_BIT=2, tx_valid held with 0x00 then 0xFF -> second start bit directly follows first stop bit; tx_busy never drops; two tx_done pulses 20 cycles apart.
- DATA_BITS=5, PARITY=0, CLKS_PER_BIT=1, send 0x1F -> txd 0,1,1,1,1,1,1, then idle; tx_done at N+8.
- Assert reset_n low mid-DATA with 0x3C in flight -> txd=1 and tx_ready=1 immediately; no tx_done; next frame after release is correct.
- tx_data toggled and tx_valid pulsed while busy -> frame bits unchanged; no extra frame is sent.
